// File: rtl/bus_seq_pkg.sv
// Shared types and constants for the register-bus sequencer.
//   state_e     : sequencer FSM states
//   req_t       : captured transfer request {imm, src, dst, data}
//   src_onehot  : source-register output-enable pattern for a request
package bus_seq_pkg;

    localparam int unsigned DefaultNregs = 8;
    localparam int unsigned DefaultSrcW  = 3;

    typedef enum logic [1:0] {
        StIdle,
        StDrive,
        StLatch,
        StHold
    } state_e;

    typedef struct packed {
        logic                    imm;
        logic [DefaultSrcW-1:0]  src;
        logic [DefaultNregs-1:0] dst;
        logic [7:0]              data;
    } req_t;

    // Immediate requests and out-of-range sources enable no register.
    function automatic logic [DefaultNregs-1:0] src_onehot(input req_t r);
        logic [DefaultNregs-1:0] v;
        v = '0;
        if (!r.imm && (int'(r.src) < int'(DefaultNregs))) begin
            v[r.src] = 1'b1;
        end
        return v;
    endfunction

endpackage

// File: rtl/bus_imm_driver.sv
// Tristate driver for immediate bytes onto the shared register bus.
//   en    : drive value onto data when high, release (Z) when low
//   value : byte to drive
//   data  : shared 8-bit tristate bus
module bus_imm_driver (
    input  logic       en,
    input  logic [7:0] value,
    inout  wire  [7:0] data
);

    assign data = en ? value : 8'hzz;

endmodule

// File: rtl/bus_sequencer.sv
// Sequences one register-bus transfer per request: enable the source for a
// full cycle, pulse the destination latches, then hold the source one more
// cycle so the latched registers see hold time.
//   clk, rst_n           : clock, asynchronous active-low reset
//   req_valid/req_ready  : request handshake
//   req_imm/src/data/dst : request payload (immediate flag, source index,
//                          immediate byte, destination mask)
//   data                 : shared tristate bus
//   oe, latch            : per-register output enables and capture strobes
//   done                 : one-cycle completion pulse
//   bus_value            : byte seen on the bus during the latch cycle
module bus_sequencer
    import bus_seq_pkg::*;
#(
    parameter int unsigned NREGS = DefaultNregs,
    parameter int unsigned SRC_W = DefaultSrcW
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_imm,
    input  logic [SRC_W-1:0] req_src,
    input  logic [7:0]       req_data,
    input  logic [NREGS-1:0] req_dst,
    inout  wire  [7:0]       data,
    output logic [NREGS-1:0] oe,
    output logic [NREGS-1:0] latch,
    output logic             done,
    output logic [7:0]       bus_value
);

    state_e state_q;
    req_t   req_q;
    req_t   new_req;
    logic   drv_en_q;
    logic   accept;

    assign accept = req_valid & req_ready;

    always_comb begin
        new_req      = '0;
        new_req.imm  = req_imm;
        new_req.src  = DefaultSrcW'(req_src);
        new_req.dst  = DefaultNregs'(req_dst);
        new_req.data = req_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            req_q     <= '0;
            oe        <= '0;
            latch     <= '0;
            drv_en_q  <= 1'b0;
            done      <= 1'b0;
            req_ready <= 1'b0;
            bus_value <= 8'h00;
        end else begin
            latch <= '0;
            done  <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    req_ready <= 1'b1;
                    oe        <= '0;
                    drv_en_q  <= 1'b0;
                    if (accept) begin
                        req_q     <= new_req;
                        oe        <= NREGS'(src_onehot(new_req));
                        drv_en_q  <= req_imm;
                        req_ready <= 1'b0;
                        state_q   <= StDrive;
                    end
                end
                StDrive: begin
                    oe       <= NREGS'(src_onehot(req_q));
                    drv_en_q <= req_q.imm;
                    latch    <= NREGS'(req_q.dst);
                    state_q  <= StLatch;
                end
                StLatch: begin
                    // Source stays on through HOLD for latch hold time.
                    oe        <= NREGS'(src_onehot(req_q));
                    drv_en_q  <= req_q.imm;
                    bus_value <= data;
                    done      <= 1'b1;
                    req_ready <= 1'b1;
                    state_q   <= StHold;
                end
                StHold: begin
                    if (accept) begin
                        // Old source off and new source on at the same edge.
                        req_q     <= new_req;
                        oe        <= NREGS'(src_onehot(new_req));
                        drv_en_q  <= req_imm;
                        req_ready <= 1'b0;
                        state_q   <= StDrive;
                    end else begin
                        oe       <= '0;
                        drv_en_q <= 1'b0;
                        state_q  <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    bus_imm_driver u_imm_driver (
        .en    (drv_en_q),
        .value (req_q.data),
        .data  (data)
    );

endmodule

// File: tb/tb_bus_sequencer.sv
module tb_bus_sequencer;

    localparam int NREGS = 8;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             req_valid;
    logic             req_ready;
    logic             req_imm;
    logic [2:0]       req_src;
    logic [7:0]       req_data;
    logic [NREGS-1:0] req_dst;
    wire  [7:0]       data;
    logic [NREGS-1:0] oe;
    logic [NREGS-1:0] latch;
    logic             done;
    logic [7:0]       bus_value;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int done_cnt = 0;

    bus_sequencer #(.NREGS(NREGS), .SRC_W(3)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_imm   (req_imm),
        .req_src   (req_src),
        .req_data  (req_data),
        .req_dst   (req_dst),
        .data      (data),
        .oe        (oe),
        .latch     (latch),
        .done      (done),
        .bus_value (bus_value)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Environment: register file on the bus.
    logic [7:0]       regs [NREGS];
    logic [NREGS-1:0] lat_prev = '0;
    logic [7:0]       tb_drv;
    logic             tb_en;

    always @(latch) begin
        for (int i = 0; i < NREGS; i++)
            if (latch[i] && !lat_prev[i]) regs[i] = data;
        lat_prev = latch;
    end

    always_comb begin
        tb_en  = 1'b0;
        tb_drv = 8'h00;
        for (int i = 0; i < NREGS; i++)
            if (oe[i]) begin
                tb_en  = 1'b1;
                tb_drv = regs[i];
            end
    end
    assign data = tb_en ? tb_drv : 8'hzz;

    // Reference model: register contents and expected completion bytes.
    logic [7:0] exp_regs [NREGS];
    logic [7:0] exp_bv_q [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
        end
    endtask

    logic done_prev = 1'b0;
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            chk("oe_onehot", 32'($countones(oe) <= 1), 1);
            if (done) begin
                done_cnt++;
                chk("done_width", done_prev, 0);
                if (exp_bv_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL done_spurious: done with no pending transfer (t=%0t)", $time);
                end else begin
                    chk("bus_value", bus_value, exp_bv_q.pop_front());
                end
            end
        end
        done_prev = done;
    end

    // Presents a request and waits for its acceptance edge; returns at edge+1.
    task automatic issue(input logic imm, input logic [2:0] src, input logic [7:0] dat,
                         input logic [7:0] dst, input bit track,
                         output int acc, output logic [7:0] val);
        int n;
        req_valid = 1'b1;
        req_imm   = imm;
        req_src   = src;
        req_data  = dat;
        req_dst   = dst;
        n = 0;
        while (!req_ready && n < 16) begin
            @(negedge clk);
            n++;
        end
        chk("ready_timeout", req_ready, 1);
        val = imm ? dat : exp_regs[src];
        if (track) begin
            exp_bv_q.push_back(val);
            for (int i = 0; i < NREGS; i++)
                if (dst[i]) exp_regs[i] = val;
        end
        @(posedge clk);
        #1;
        acc = cyc;
        req_valid = 1'b0;
    endtask

    // One isolated transfer with cycle-by-cycle output checks.
    task automatic xfer_checked(input logic imm, input logic [2:0] src, input logic [7:0] dat,
                                input logic [7:0] dst);
        int         acc;
        logic [7:0] val;
        logic [7:0] exp_oe;
        exp_oe = '0;
        if (!imm) exp_oe[src] = 1'b1;
        issue(imm, src, dat, dst, 1'b1, acc, val);
        @(negedge clk);
        chk("drive_oe", oe, exp_oe);
        chk("drive_latch", latch, 0);
        chk("drive_ready", req_ready, 0);
        chk("drive_bus", data, val);
        @(negedge clk);
        chk("latch_latch", latch, dst);
        chk("latch_oe", oe, exp_oe);
        chk("latch_ready", req_ready, 0);
        @(negedge clk);
        chk("hold_latch", latch, 0);
        chk("hold_done", done, 1);
        chk("hold_ready", req_ready, 1);
        chk("hold_oe", oe, exp_oe);
        @(negedge clk);
        chk("idle_oe", oe, 0);
        chk("idle_done", done, 0);
        for (int i = 0; i < NREGS; i++) chk("reg_model", regs[i], exp_regs[i]);
    endtask

    typedef struct {
        logic       imm;
        logic [2:0] src;
        logic [7:0] dat;
        logic [7:0] dst;
        logic [7:0] exp_bv;
    } vec_t;

    vec_t vecs [5];

    initial begin
        int         acc [4];
        int         a;
        int         d0;
        int         n;
        logic [7:0] v;

        vecs[0] = '{1'b1, 3'd0, 8'hA5, 8'h08, 8'hA5};  // preload reg 3
        vecs[1] = '{1'b0, 3'd3, 8'h00, 8'h41, 8'hA5};  // copy 3 -> 0,6
        vecs[2] = '{1'b1, 3'd0, 8'h3C, 8'hFF, 8'h3C};  // broadcast
        vecs[3] = '{1'b1, 3'd0, 8'h77, 8'h00, 8'h77};  // no destination
        vecs[4] = '{1'b0, 3'd5, 8'h00, 8'h20, 8'h3C};  // self-copy

        for (int i = 0; i < NREGS; i++) begin
            exp_regs[i] = 8'h00;
            regs[i]     = 8'h00;
        end
        req_valid = 1'b0;
        req_imm   = 1'b0;
        req_src   = '0;
        req_data  = '0;
        req_dst   = '0;
        rst_n     = 1'b0;

        repeat (2) @(negedge clk);
        chk("rst_ready", req_ready, 0);
        chk("rst_oe", oe, 0);
        chk("rst_latch", latch, 0);
        chk("rst_done", done, 0);
        chk("rst_bus_value", bus_value, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("ready_after_rst", req_ready, 1);

        // Reset asserted while in LATCH.
        issue(1'b1, 3'd0, 8'h5A, 8'h01, 1'b0, a, v);
        @(posedge clk);
        #2;
        chk("pre_rst_latch", latch, 8'h01);
        rst_n = 1'b0;
        #1;
        chk("midrst_latch", latch, 0);
        chk("midrst_oe", oe, 0);
        chk("midrst_done", done, 0);
        chk("midrst_ready", req_ready, 0);
        chk("midrst_bus_value", bus_value, 0);
        exp_regs[0] = 8'h5A;  // latch edge preceded the reset
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("ready_after_midrst", req_ready, 1);

        for (int i = 0; i < 5; i++) begin
            xfer_checked(vecs[i].imm, vecs[i].src, vecs[i].dat, vecs[i].dst);
            chk("vec_bus_value", bus_value, vecs[i].exp_bv);
            if (i == 1) begin
                chk("copy_reg0", regs[0], 8'hA5);
                chk("copy_reg6", regs[6], 8'hA5);
            end
        end
        for (int i = 0; i < NREGS; i++) chk("final_table_reg", regs[i], 8'h3C);

        // Back-to-back with valid held.
        d0 = done_cnt;
        issue(1'b1, 3'd0, 8'h11, 8'h01, 1'b1, acc[0], v);
        issue(1'b0, 3'd0, 8'h00, 8'h02, 1'b1, acc[1], v);
        issue(1'b1, 3'd0, 8'h22, 8'h04, 1'b1, acc[2], v);
        issue(1'b0, 3'd2, 8'h00, 8'h08, 1'b1, acc[3], v);
        for (int k = 1; k < 4; k++) chk("b2b_spacing", acc[k] - acc[0], 3 * k);
        repeat (4) @(negedge clk);
        chk("b2b_done_count", done_cnt - d0, 4);
        for (int i = 0; i < NREGS; i++) chk("b2b_reg", regs[i], exp_regs[i]);

        // Randomized traffic.
        for (int t = 0; t < 1000; t++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            issue(1'($urandom), 3'($urandom), 8'($urandom), 8'($urandom), 1'b1, a, v);
        end
        n = 0;
        while (exp_bv_q.size() != 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("drain", exp_bv_q.size(), 0);
        @(negedge clk);
        for (int i = 0; i < NREGS; i++) chk("rand_reg", regs[i], exp_regs[i]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
